efuse_bank_ctrl: RTL

Parametrised successor to the single-word efuse controller. It drives a multi-bank efuse macro through the pgenb/strobe/nr/q/we pins. It adds:
- automatic boot read of all banks into a shadow register;
- bank-addressed write and read;
- skipping of zero bits during programming;
- post-program read-back verify.

It sits between main_state_machine (the wr/rd/ack/done handshake) and the efuse macro pins at top level.

---
 rtl/efuse_bank_ctrl.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/efuse_bank_ctrl.sv
// Multi-bank efuse controller: boot-loads every bank into a shadow register,
// then serves bank-addressed program/read requests. Programming skips zero
// bits and is followed by a read-back verify against (data_in | shadow).
// BANK_W may be wider than clog2(BANKS); such out-of-range indices are
// acknowledged and completed without touching the macro.
module efuse_bank_ctrl #(
  parameter int DATA_W  = 32,
  parameter int BANKS   = 4,
  parameter int BANK_W  = 2,
  parameter int T_SETUP = 1,
  parameter int T_RD    = 2,
  parameter int T_PGM   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [BANK_W-1:0]       bank,
  input  logic [DATA_W-1:0]       data_in,
  output logic                    ack,
  output logic                    done,
  output logic                    busy,
  output logic [DATA_W-1:0]       data_out,
  output logic                    verr,
  output logic                    boot_done,
  output logic [BANKS*DATA_W-1:0] shadow_out,
  output logic                    pgenb,
  output logic                    strobe,
  output logic                    nr,
  input  logic                    q,
  output logic [DATA_W-1:0]       we,
  output logic [BANKS-1:0]        bank_en
);

  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int TMAX   = (T_PGM > T_RD) ? ((T_PGM > T_SETUP) ? T_PGM : T_SETUP)
                                         : ((T_RD > T_SETUP) ? T_RD : T_SETUP);
  localparam int CNT_W  = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CNT_W-1:0]  SETUP_END = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0]  RD_END    = CNT_W'(T_RD - 1);
  localparam logic [CNT_W-1:0]  PGM_END   = CNT_W'(T_PGM - 1);
  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_W - 1);
  localparam logic [BSEL_W-1:0] LAST_BANK = BSEL_W'(BANKS - 1);
  localparam logic [BANK_W:0]   BANKS_L   = (BANK_W + 1)'(BANKS);

  typedef enum logic [3:0] {
    BOOT, IDLE, P_SETUP, P_STROBE, P_HOLD, R_SETUP, R_STROBE, R_HOLD, CHECK, FIN
  } state_t;

  typedef enum logic [1:0] {OP_BOOT, OP_RD, OP_WR} op_t;

  state_t                         state;
  op_t                            op;
  logic [BANK_W-1:0]              bank_q;
  logic [DATA_W-1:0]              wdata;
  logic [DATA_W-1:0]              rdata;
  logic [IDX_W-1:0]               idx;
  logic [CNT_W-1:0]               cnt;
  logic [BANKS-1:0][DATA_W-1:0]   shadow;

  logic [BSEL_W-1:0]              bsel;
  logic [IDX_W-1:0]               nxt_idx;
  logic                           last_bit;
  logic                           bank_ok;
  logic                           pgm_adv;

  function automatic logic [DATA_W-1:0] bit_sel(input logic [IDX_W-1:0] i);
    return DATA_W'(1) << i;
  endfunction

  function automatic logic [BANKS-1:0] bank_sel(input logic [BSEL_W-1:0] b);
    return BANKS'(1) << b;
  endfunction

  assign shadow_out = shadow;
  assign bsel       = bank_q[BSEL_W-1:0];
  assign nxt_idx    = idx + 1'b1;
  assign last_bit   = (idx == LAST_BIT);
  assign bank_ok    = ({1'b0, bank} < BANKS_L);

  // A program slot ends after its hold cycle, or at once when the bit is zero.
  always_comb begin
    pgm_adv = 1'b0;
    if (state == P_HOLD)                    pgm_adv = 1'b1;
    else if (state == P_SETUP && !wdata[idx]) pgm_adv = 1'b1;
  end

  // Controller FSM; every macro pin and handshake output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      op        <= OP_BOOT;
      bank_q    <= '0;
      wdata     <= '0;
      rdata     <= '0;
      idx       <= '0;
      cnt       <= '0;
      shadow    <= '0;
      ack       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b1;
      data_out  <= '0;
      verr      <= 1'b0;
      boot_done <= 1'b0;
      pgenb     <= 1'b1;
      strobe    <= 1'b0;
      nr        <= 1'b0;
      we        <= '0;
      bank_en   <= '0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      case (state)
        BOOT: begin
          op      <= OP_BOOT;
          bank_q  <= '0;
          idx     <= '0;
          cnt     <= '0;
          nr      <= 1'b1;
          pgenb   <= 1'b1;
          we      <= bit_sel('0);
          bank_en <= bank_sel('0);
          state   <= R_SETUP;
        end
        IDLE: begin
          if (wr || rd) begin
            ack    <= 1'b1;
            busy   <= 1'b1;
            bank_q <= bank;
            wdata  <= data_in;
            idx    <= '0;
            cnt    <= '0;
            op     <= wr ? OP_WR : OP_RD;
            if (wr) verr <= !bank_ok;
            if (!bank_ok) begin
              state <= FIN;
            end else if (wr) begin
              pgenb   <= 1'b0;
              nr      <= 1'b0;
              we      <= data_in[0] ? bit_sel('0) : '0;
              bank_en <= bank_sel(bank[BSEL_W-1:0]);
              state   <= P_SETUP;
            end else begin
              nr      <= 1'b1;
              we      <= bit_sel('0);
              bank_en <= bank_sel(bank[BSEL_W-1:0]);
              state   <= R_SETUP;
            end
          end
        end
        P_SETUP, P_HOLD: begin
          if (pgm_adv) begin
            cnt <= '0;
            if (last_bit) begin
              // Word programmed: switch straight into the verify read.
              idx   <= '0;
              pgenb <= 1'b1;
              nr    <= 1'b1;
              we    <= bit_sel('0);
              state <= R_SETUP;
            end else begin
              idx   <= nxt_idx;
              we    <= wdata[nxt_idx] ? bit_sel(nxt_idx) : '0;
              state <= P_SETUP;
            end
          end else if (cnt == SETUP_END) begin
            cnt    <= '0;
            strobe <= 1'b1;
            state  <= P_STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        P_STROBE: begin
          if (cnt == PGM_END) begin
            cnt    <= '0;
            strobe <= 1'b0;
            state  <= P_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_SETUP: begin
          if (cnt == SETUP_END) begin
            cnt    <= '0;
            strobe <= 1'b1;
            state  <= R_STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_STROBE: begin
          if (cnt == RD_END) begin
            cnt        <= '0;
            strobe     <= 1'b0;
            rdata[idx] <= q;
            state      <= R_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_HOLD: begin
          cnt <= '0;
          if (!last_bit) begin
            idx   <= nxt_idx;
            we    <= bit_sel(nxt_idx);
            state <= R_SETUP;
          end else begin
            idx     <= '0;
            nr      <= 1'b0;
            we      <= '0;
            bank_en <= '0;
            case (op)
              OP_BOOT: begin
                shadow[bsel] <= rdata;
                if (bsel == LAST_BANK) begin
                  boot_done <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
                end else begin
                  bank_q  <= bank_q + 1'b1;
                  nr      <= 1'b1;
                  we      <= bit_sel('0);
                  bank_en <= bank_sel(bsel + 1'b1);
                  state   <= R_SETUP;
                end
              end
              OP_RD: begin
                shadow[bsel] <= rdata;
                data_out     <= rdata;
                done         <= 1'b1;
                busy         <= 1'b0;
                state        <= FIN;
              end
              default: state <= CHECK;
            endcase
          end
        end
        CHECK: begin
          verr         <= (rdata != (wdata | shadow[bsel]));
          shadow[bsel] <= rdata;
          data_out     <= rdata;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= FIN;
        end
        FIN: begin
          // Out-of-range requests arrive here without done; raise it now.
          if (!done) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
